// File: rtl/xlr8_dm_initiator.sv
// xlr8_dm_initiator: bus initiator for the AVR data-memory register interface of XB wrappers.
// Accepts 8-bit register read/write commands through a small command queue and issues them
// one at a time on the XB bus (dm_sel/ramadr/ramre/ramwe/bus_wdata). Each command gets exactly
// one response, in command order: read data, zero for writes, or an error if a read times out.
//
// Ports
//   clk, rst                     single clock, synchronous active-high reset
//   clken                        bus clock enable; an access only completes when clken=1
//   cmd_valid/cmd_ready          command handshake; cmd_write/cmd_addr/cmd_wdata payload
//   rsp_valid/rsp_ready          response handshake; rsp_rdata/rsp_err payload
//   busy                         queue non-empty or an access/response in flight
//   dm_sel/ramadr/ramre/ramwe    registered bus strobes and address to the XB
//   bus_wdata                    registered write data to the XB dbus_in
//   bus_rdata/io_out_en          XB read data and its qualifier
module xlr8_dm_initiator #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic       dm_sel,
  output logic [7:0] ramadr,
  output logic       ramre,
  output logic       ramwe,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       io_out_en
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned TcntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  // Command queue: entry is {write, addr, wdata}
  logic [16:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, empty, push, pop;

  state_e          state_q;
  logic            acc_write_q;
  logic [7:0]      acc_addr_q;
  logic [7:0]      acc_wdata_q;
  logic [TcntW-1:0] tcnt_q;

  assign full      = (count_q == CntFull);
  assign empty     = (count_q == '0);
  assign push      = cmd_valid && !full;
  assign pop       = (state_q == StIdle) && !empty;
  assign cmd_ready = !full;
  assign busy      = !empty || (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Access FSM. The first ACCESS cycle (dm_sel still 0) only launches the registered bus
  // outputs; completion is evaluated once the strobes are actually on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_write_q <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      tcnt_q      <= '0;
      dm_sel      <= 1'b0;
      ramadr      <= '0;
      ramre       <= 1'b0;
      ramwe       <= 1'b0;
      bus_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            {acc_write_q, acc_addr_q, acc_wdata_q} <= mem_q[rd_ptr_q];
            tcnt_q  <= '0;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (!dm_sel) begin
            dm_sel    <= 1'b1;
            ramadr    <= acc_addr_q;
            ramwe     <= acc_write_q;
            ramre     <= !acc_write_q;
            bus_wdata <= acc_write_q ? acc_wdata_q : 8'h00;
          end else if (clken) begin
            if (acc_write_q || io_out_en || (tcnt_q == TcntLast)) begin
              dm_sel    <= 1'b0;
              ramadr    <= '0;
              ramre     <= 1'b0;
              ramwe     <= 1'b0;
              bus_wdata <= '0;
              rsp_valid <= 1'b1;
              rsp_rdata <= (!acc_write_q && io_out_en) ? bus_rdata : 8'h00;
              rsp_err   <= !acc_write_q && !io_out_en;
              state_q   <= StResp;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
